// File: rtl/memlcd_rx_pkg.sv
// Shared FSM state type and frame-field constants for the memory-LCD receiver.
package memlcd_pkg;

  typedef enum logic [2:0] {IDLE, MODE, ADDR, DATA, TRAIL, SKIP} state_t;

  localparam int MODE_BITS  = 6;
  localparam int ADDR_BITS  = 10;
  localparam int TRAIL_BITS = 6;

  localparam int M0 = 0;
  localparam int M1 = 1;
  localparam int M2 = 2;

endpackage

// File: rtl/memlcd_rx_if.sv
// Decoded pixel/command output bundle of memlcd_rx (master drives, slave consumes).
interface memlcd_rx_if #(parameter int COLS = 336);

  logic                          px_valid;
  logic [7:0]                    px_data;
  logic [$clog2(COLS/8)-1:0]     px_col;
  logic [9:0]                    px_line;
  logic                          px_last;
  logic                          clr_pulse;
  logic                          vcom;
  logic                          err_pulse;

  modport master (output px_valid, px_data, px_col, px_line, px_last,
                         clr_pulse, vcom, err_pulse);
  modport slave  (input  px_valid, px_data, px_col, px_line, px_last,
                         clr_pulse, vcom, err_pulse);

endinterface

// File: rtl/memlcd_rx_sync.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized level.
module memlcd_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              q_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      q_d   <= 1'b0;
    end else begin
      chain <= (chain << 1) | STAGES'(d);
      q_d   <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/memlcd_rx.sv
// Memory-LCD serial receiver: decodes mode/address/pixel stream into byte strobes.
// Define MEMLCD_RX_STATS_EN to add line_count/err_count outputs.
module memlcd_rx
  import memlcd_pkg::*;
#(
  parameter int COLS        = 336,
  parameter int ROWS        = 536,
  parameter int SYNC_STAGES = 2
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        lcd_sclk,
  input  logic        lcd_si,
  input  logic        lcd_scs,
  memlcd_rx_if.master px
`ifdef MEMLCD_RX_STATS_EN
  ,
  output logic [15:0] line_count,
  output logic [7:0]  err_count
`endif
);

  localparam int COL_W = $clog2(COLS/8);
  localparam int CNT_W = $clog2(COLS) + 1;

  // index 0: sclk, 1: si, 2: scs
  logic [2:0] pins, sync_q, sync_rise, sync_fall;
  assign pins = {lcd_scs, lcd_si, lcd_sclk};

  for (genvar i = 0; i < 3; i++) begin : g_sync
    memlcd_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (refclk),
      .rst (rst),
      .d   (pins[i]),
      .q   (sync_q[i]),
      .rise(sync_rise[i]),
      .fall(sync_fall[i])
    );
  end

  state_t                 state, nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [ADDR_BITS-1:0]   sr;
  logic [MODE_BITS-1:0]   mword;
  logic [ADDR_BITS-1:0]   aword;
  logic [7:0]             bword;
  logic [SYNC_STAGES:0]   settle;
  logic si, bit_en, fall_evt, fall_pend, start, armed;
  logic sup, done, addr_bad;
  logic err_set, clr_set, vcom_ld, addr_ld, byte_set, last_set;

  assign si = sync_q[1];
  // A bit coinciding with scs falling is still taken; the fall is handled a cycle later.
  assign bit_en   = sync_rise[0] & (sync_q[2] | sync_fall[2]);
  assign fall_evt = (sync_fall[2] & ~sync_rise[0]) | fall_pend;
  assign start    = sync_rise[2] & armed;

  // Fields are LSB first, so the word completed by the current bit has si on top.
  assign mword    = {si, sr[ADDR_BITS-1 -: MODE_BITS-1]};
  assign aword    = {si, sr[ADDR_BITS-1:1]};
  assign bword    = {si, sr[ADDR_BITS-1 -: 7]};
  assign addr_bad = (aword == '0) || (int'(aword) > ROWS);

  logic unused_ok;
  assign unused_ok = ^{sync_q[0], sync_rise[1], sync_fall[1:0],
                       mword[MODE_BITS-1:3], sr[0]};

  always_ff @(posedge refclk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (fall_evt) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE:  if (start) nxt = MODE;
        MODE:  if (bit_en && cnt == CNT_W'(MODE_BITS-1))
                 nxt = mword[M2] ? SKIP : (mword[M0] ? ADDR : SKIP);
        ADDR:  if (bit_en && cnt == CNT_W'(ADDR_BITS-1))  nxt = DATA;
        DATA:  if (bit_en && cnt == CNT_W'(COLS-1))       nxt = TRAIL;
        TRAIL: if (bit_en && cnt == CNT_W'(TRAIL_BITS-1)) nxt = ADDR;
        default: nxt = state;
      endcase
    end
  end

  always_comb begin
    done     = (nxt != state);
    cnt_nxt  = cnt;
    err_set  = 1'b0;
    clr_set  = 1'b0;
    vcom_ld  = 1'b0;
    addr_ld  = 1'b0;
    byte_set = 1'b0;
    last_set = 1'b0;
    if (fall_evt) begin
      cnt_nxt = '0;
      // IDLE covers a fall after a mid-frame reset, which must stay silent.
      err_set = !(state == IDLE || state == SKIP || (state == ADDR && cnt == '0));
    end else if (state == IDLE) begin
      if (start) cnt_nxt = '0;
    end else if (bit_en && state != SKIP) begin
      cnt_nxt = done ? '0 : cnt + CNT_W'(1);
      case (state)
        MODE: if (done) begin
          vcom_ld = 1'b1;
          clr_set = mword[M2];
        end
        ADDR: if (done) begin
          addr_ld = 1'b1;
          err_set = addr_bad;
        end
        DATA: if (cnt[2:0] == 3'd7 && !sup) begin
          byte_set = 1'b1;
          last_set = (cnt == CNT_W'(COLS-1));
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      cnt          <= '0;
      sr           <= '0;
      sup          <= 1'b0;
      fall_pend    <= 1'b0;
      settle       <= '0;
      armed        <= 1'b0;
      px.px_valid  <= 1'b0;
      px.px_data   <= '0;
      px.px_col    <= '0;
      px.px_line   <= '0;
      px.px_last   <= 1'b0;
      px.clr_pulse <= 1'b0;
      px.vcom      <= 1'b0;
      px.err_pulse <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      if (bit_en) sr <= {si, sr[ADDR_BITS-1:1]};
      fall_pend <= sync_fall[2] & sync_rise[0];
      // Only a scs rise seen after scs was low post-reset may open a frame.
      settle    <= {settle[SYNC_STAGES-1:0], 1'b1};
      if (settle[SYNC_STAGES] && !sync_q[2]) armed <= 1'b1;
      if (addr_ld) sup <= addr_bad;
      px.px_valid <= byte_set;
      px.px_last  <= last_set;
      if (byte_set) begin
        px.px_data <= bword;
        px.px_col  <= cnt[3 +: COL_W];
      end
      if (addr_ld && !addr_bad) px.px_line <= aword;
      if (vcom_ld) px.vcom <= mword[M1];
      px.clr_pulse <= clr_set;
      px.err_pulse <= err_set;
    end
  end

`ifdef MEMLCD_RX_STATS_EN
  always_ff @(posedge refclk) begin
    if (rst) begin
      line_count <= '0;
      err_count  <= '0;
    end else begin
      if (last_set) line_count <= line_count + 16'd1;
      if (err_set && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule
